// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: arbiter state encoding and
// SDRAM command codes, packed as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    localparam int CMD_W = 4;

    // Bit positions of each command pin within a 4-bit command word
    localparam int CMD_CS_N_BIT  = 3;
    localparam int CMD_RAS_N_BIT = 2;
    localparam int CMD_CAS_N_BIT = 1;
    localparam int CMD_WE_N_BIT  = 0;

    localparam logic [CMD_W-1:0] CMD_LMR        = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_AREF       = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE      = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ       = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_NOP        = 4'b0111;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational pin mux: selects which engine's command/bank/address reaches
// the SDRAM pins based on the arbiter state. ARBIT (and any unknown state) emits NOP.
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  arb_state_t         i_state,
    input  logic [CMD_W-1:0]   i_init_cmd,
    input  logic [BA_W-1:0]    i_init_ba,
    input  logic [ADDR_W-1:0]  i_init_addr,
    input  logic [CMD_W-1:0]   i_aref_cmd,
    input  logic [BA_W-1:0]    i_aref_ba,
    input  logic [ADDR_W-1:0]  i_aref_addr,
    input  logic [CMD_W-1:0]   i_wr_cmd,
    input  logic [BA_W-1:0]    i_wr_ba,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [CMD_W-1:0]   i_rd_cmd,
    input  logic [BA_W-1:0]    i_rd_ba,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [CMD_W-1:0]   o_cmd,
    output logic [BA_W-1:0]    o_ba,
    output logic [ADDR_W-1:0]  o_addr
);

    always_comb begin
        o_cmd  = CMD_NOP;
        o_ba   = '0;
        o_addr = '0;
        case (i_state)
            ST_IDLE: begin
                o_cmd  = i_init_cmd;
                o_ba   = i_init_ba;
                o_addr = i_init_addr;
            end
            ST_AREF: begin
                o_cmd  = i_aref_cmd;
                o_ba   = i_aref_ba;
                o_addr = i_aref_addr;
            end
            ST_WRITE: begin
                o_cmd  = i_wr_cmd;
                o_ba   = i_wr_ba;
                o_addr = i_wr_addr;
            end
            ST_READ: begin
                o_cmd  = i_rd_cmd;
                o_ba   = i_rd_ba;
                o_addr = i_rd_addr;
            end
            default: begin
                o_cmd  = CMD_NOP;
                o_ba   = '0;
                o_addr = '0;
            end
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init/refresh/write/read engines one at a time
// (refresh > write > read), drives the command pins and owns the dq tri-state.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               init_end,
    input  logic [CMD_W-1:0]   init_cmd,
    input  logic [BA_W-1:0]    init_ba,
    input  logic [ADDR_W-1:0]  init_addr,
    input  logic               aref_req,
    input  logic               aref_end,
    input  logic [CMD_W-1:0]   aref_cmd,
    input  logic [BA_W-1:0]    aref_ba,
    input  logic [ADDR_W-1:0]  aref_addr,
    output logic               aref_en,
    input  logic               wr_req,
    input  logic               wr_end,
    input  logic [CMD_W-1:0]   wr_cmd,
    input  logic [BA_W-1:0]    wr_ba,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_sdram_en,
    input  logic [DATA_W-1:0]  wr_sdram_data,
    output logic               wr_en,
    input  logic               rd_req,
    input  logic               rd_end,
    input  logic [CMD_W-1:0]   rd_cmd,
    input  logic [BA_W-1:0]    rd_ba,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_en,
    output logic [DATA_W-1:0]  rd_sdram_data,
    output logic               sdram_cke,
    output logic               sdram_cs_n,
    output logic               sdram_ras_n,
    output logic               sdram_cas_n,
    output logic               sdram_we_n,
    output logic [BA_W-1:0]    sdram_ba,
    output logic [ADDR_W-1:0]  sdram_addr,
    inout  wire  [DATA_W-1:0]  sdram_dq
);

    arb_state_t         r_state;
    logic               r_aref_en;
    logic               r_wr_en;
    logic               r_rd_en;
    logic [CMD_W-1:0]   w_cmd;
    logic               w_dq_oe;

    // Grants change together with the state, so a *_end pulse can only close
    // the burst of the engine that currently owns the bus.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (init_end) begin
                        r_state <= ST_ARBIT;
                    end
                end
                ST_ARBIT: begin
                    if (aref_req) begin
                        r_state   <= ST_AREF;
                        r_aref_en <= 1'b1;
                    end else if (wr_req) begin
                        r_state <= ST_WRITE;
                        r_wr_en <= 1'b1;
                    end else if (rd_req) begin
                        r_state <= ST_READ;
                        r_rd_en <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        r_state   <= ST_ARBIT;
                        r_aref_en <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        r_state <= ST_ARBIT;
                        r_wr_en <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        r_state <= ST_ARBIT;
                        r_rd_en <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_aref_en <= 1'b0;
                    r_wr_en   <= 1'b0;
                    r_rd_en   <= 1'b0;
                end
            endcase
        end
    end

    assign aref_en = r_aref_en;
    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;

    sdram_cmd_mux #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W)
    ) u_cmd_mux (
        .i_state     (r_state),
        .i_init_cmd  (init_cmd),
        .i_init_ba   (init_ba),
        .i_init_addr (init_addr),
        .i_aref_cmd  (aref_cmd),
        .i_aref_ba   (aref_ba),
        .i_aref_addr (aref_addr),
        .i_wr_cmd    (wr_cmd),
        .i_wr_ba     (wr_ba),
        .i_wr_addr   (wr_addr),
        .i_rd_cmd    (rd_cmd),
        .i_rd_ba     (rd_ba),
        .i_rd_addr   (rd_addr),
        .o_cmd       (w_cmd),
        .o_ba        (sdram_ba),
        .o_addr      (sdram_addr)
    );

    assign sdram_cke   = 1'b1;
    assign sdram_cs_n  = w_cmd[CMD_CS_N_BIT];
    assign sdram_ras_n = w_cmd[CMD_RAS_N_BIT];
    assign sdram_cas_n = w_cmd[CMD_CAS_N_BIT];
    assign sdram_we_n  = w_cmd[CMD_WE_N_BIT];

    // The write engine may only drive the bus while it actually owns it.
    assign w_dq_oe       = (r_state == ST_WRITE) && wr_sdram_en;
    assign sdram_dq      = w_dq_oe ? wr_sdram_data : {DATA_W{1'bz}};
    assign rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized scoreboard bench for sdram_arbit: a transaction-level bus-ownership
// model predicts grants, pins and dq each cycle; a negedge monitor compares.
module tb_sdram_arbit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              aref_req, aref_end;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_en;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DATA_W-1:0] wr_sdram_data;
    logic              wr_en;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_sdram_data;
    logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    wire  [DATA_W-1:0] sdram_dq;

    // Bench-side "memory" driver: it drives the bus whenever the arbiter must not.
    logic              tb_dq_oe;
    logic [DATA_W-1:0] tb_dq_val;
    assign sdram_dq = tb_dq_oe ? tb_dq_val : {DATA_W{1'bz}};

    always #5 sys_clk = ~sys_clk;

    sdram_arbit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
        .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_en(aref_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .wr_en(wr_en), .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_en(rd_en), .rd_sdram_data(rd_sdram_data),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
    );

    typedef struct packed {
        logic [2:0]        grants;   // {rd, wr, aref}
        logic [3:0]        cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: who owns the bus. owner = -2 waiting for init,
    // -1 free (arbitration cycle), 0 refresh, 1 write, 2 read.
    int m_owner = -2;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    task automatic randomize_pins();
        init_cmd  = 4'($urandom); init_ba = BA_W'($urandom); init_addr = ADDR_W'($urandom);
        aref_cmd  = 4'($urandom); aref_ba = BA_W'($urandom); aref_addr = ADDR_W'($urandom);
        wr_cmd    = 4'($urandom); wr_ba   = BA_W'($urandom); wr_addr   = ADDR_W'($urandom);
        rd_cmd    = 4'($urandom); rd_ba   = BA_W'($urandom); rd_addr   = ADDR_W'($urandom);
        tb_dq_val = DATA_W'($urandom);
    endtask

    // Predict this cycle's outputs from the model, queue them, then advance one edge.
    task automatic step();
        exp_t              e;
        logic [3:0]        cmds  [3];
        logic [BA_W-1:0]   bas   [3];
        logic [ADDR_W-1:0] addrs [3];
        logic              reqs  [3];
        logic              ends  [3];
        logic              dut_drives;
        randomize_pins();
        cmds  = '{aref_cmd, wr_cmd, rd_cmd};
        bas   = '{aref_ba, wr_ba, rd_ba};
        addrs = '{aref_addr, wr_addr, rd_addr};
        reqs  = '{aref_req, wr_req, rd_req};
        ends  = '{aref_end, wr_end, rd_end};

        if (m_owner == -2) begin
            e.grants = 3'b000; e.cmd = init_cmd; e.ba = init_ba; e.addr = init_addr;
        end else if (m_owner == -1) begin
            e.grants = 3'b000; e.cmd = 4'b0111; e.ba = '0; e.addr = '0;
        end else begin
            e.grants = 3'b001 << m_owner;
            e.cmd = cmds[m_owner]; e.ba = bas[m_owner]; e.addr = addrs[m_owner];
        end
        dut_drives = (m_owner == 1) && wr_sdram_en;
        tb_dq_oe   = !dut_drives;
        e.rdata    = dut_drives ? wr_sdram_data : tb_dq_val;
        exp_q.push_back(e);

        if (sys_rst) begin
            m_owner = -2;
        end else if (m_owner == -2) begin
            if (init_end) m_owner = -1;
        end else if (m_owner == -1) begin
            for (int k = 2; k >= 0; k--) if (reqs[k]) m_owner = k;
        end else if (ends[m_owner]) begin
            m_owner = -1;
        end

        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_end(input int which);
        case (which)
            0: aref_end = 1'b1;
            1: wr_end   = 1'b1;
            default: rd_end = 1'b1;
        endcase
        step();
        aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("cycle=%0d grants=%b cmd=%b ba=%h addr=%h rdata=%h",
                     cyc, {rd_en, wr_en, aref_en},
                     {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                     sdram_ba, sdram_addr, rd_sdram_data);
            check("grants", 32'({rd_en, wr_en, aref_en}), 32'(e.grants));
            check("grant_onehot", 32'($countones({rd_en, wr_en, aref_en}) <= 1), 32'(1));
            check("cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e.cmd));
            check("ba", 32'(sdram_ba), 32'(e.ba));
            check("addr", 32'(sdram_addr), 32'(e.addr));
            check("dq", 32'(rd_sdram_data), 32'(e.rdata));
            check("cke", 32'(sdram_cke), 32'(1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int init_hold;
        sys_rst = 1'b1; init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0; wr_sdram_en = 1'b0; wr_sdram_data = '0;
        tb_dq_oe = 1'b1;
        randomize_pins();
        @(posedge sys_clk);
        #1;
        step();
        sys_rst = 1'b0;

        // Held in init for a long time: pins follow init_*, no grants.
        steps(100);

        // Init done, write request: grant two cycles later; dq driven in WRITE.
        init_end = 1'b1; wr_req = 1'b1;
        steps(3);
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
        steps(2);
        wr_sdram_en = 1'b0; wr_req = 1'b0;
        pulse_end(1);
        steps(2);

        // All three requests together: refresh, then write, then read.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        steps(3);
        aref_req = 1'b0; pulse_end(0);
        steps(3);
        wr_req = 1'b0; pulse_end(1);
        steps(2);
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
        steps(2);
        wr_sdram_en = 1'b0; rd_req = 1'b0;
        pulse_end(2);
        steps(2);

        // Refresh arriving mid-write waits for the write to finish.
        wr_req = 1'b1;
        steps(3);
        aref_req = 1'b1;
        steps(3);
        wr_req = 1'b0; pulse_end(1);
        steps(3);
        aref_req = 1'b0; pulse_end(0);
        steps(2);

        // Reset in the middle of a read; a later rd_end is ignored.
        rd_req = 1'b1;
        steps(4);
        sys_rst = 1'b1; init_end = 1'b0;
        step();
        sys_rst = 1'b0;
        pulse_end(2);
        steps(2);
        init_end = 1'b1;
        steps(3);
        rd_req = 1'b0; pulse_end(2);
        steps(2);

        // Randomized traffic including stray end pulses and occasional resets.
        init_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            sys_rst       = ($urandom_range(0, 299) == 0);
            init_end      = (init_hold == 0);
            if (init_hold > 0) init_hold--;
            if ($urandom_range(0, 5) == 0) aref_req = ~aref_req;
            if ($urandom_range(0, 5) == 0) wr_req   = ~wr_req;
            if ($urandom_range(0, 5) == 0) rd_req   = ~rd_req;
            aref_end      = ($urandom_range(0, 5) == 0);
            wr_end        = ($urandom_range(0, 5) == 0);
            rd_end        = ($urandom_range(0, 5) == 0);
            wr_sdram_en   = 1'($urandom);
            wr_sdram_data = DATA_W'($urandom);
            if (sys_rst) init_hold = $urandom_range(0, 6);
            step();
        end
        sys_rst = 1'b0;
        aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;

        @(negedge sys_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
